alu_pipe: RTL

Parametrised, handshaked successor to the execute-stage ALU. It accepts one operation per transfer on a valid/ready input port and computes the result in a single cycle, except MUL, which uses an iterative shift-add multiplier. The result and its instruction tag go into a single-entry output register with valid/ready back-pressure. The block also keeps a persistent compare-flags register in place of the hard-wired register-file write, and sits between operand fetch and writeback/memory.

---
 rtl/alu_pipe.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU: single-cycle ops, iterative shift-add MUL,
// single-entry result register with back-pressure, and a sticky CMP flags register.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int IMMW  = 5,
    parameter int TAGW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [IMMW-1:0]  in_imm,
    input  logic             in_use_imm,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAGW-1:0]  out_tag,
    output logic [1:0]       cmp_flags,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_LD  = 4'd1;
    localparam logic [3:0] OP_ST  = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_LSL = 4'd10;
    localparam logic [3:0] OP_LSR = 4'd11;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mul_a_q, mul_a_d;
    logic [WIDTH-1:0]  mul_b_q, mul_b_d;
    logic [WIDTH-1:0]  prod_q, prod_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [TAGW-1:0]   mul_tag_q, mul_tag_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_result_q, out_result_d;
    logic [TAGW-1:0]   out_tag_q, out_tag_d;
    logic [1:0]        cmp_flags_q, cmp_flags_d;

    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH-1:0]  alu_result;
    logic [WIDTH-1:0]  prod_sum;
    logic              in_fire;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign busy     = (state_q == MUL);

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign cmp_flags  = cmp_flags_q;

    always_comb begin
        b_eff      = in_use_imm ? WIDTH'(in_imm) : in_b;
        alu_result = '0;
        case (in_op)
            OP_ADD, OP_LD, OP_ST: alu_result = in_a + b_eff;
            OP_SUB:               alu_result = in_a - b_eff;
            OP_CMP:               alu_result = (in_a == b_eff) ? WIDTH'(1) : '0;
            OP_MOV:               alu_result = b_eff;
            OP_OR:                alu_result = in_a | b_eff;
            OP_AND:               alu_result = in_a & b_eff;
            OP_NOT:               alu_result = ~in_a;
            // Out-of-range shift amounts flush to zero regardless of operator semantics.
            OP_LSL:               alu_result = (b_eff >= WIDTH_V) ? '0 : (in_a << b_eff);
            OP_LSR:               alu_result = (b_eff >= WIDTH_V) ? '0 : (in_a >> b_eff);
            default:              alu_result = '0;
        endcase
    end

    assign prod_sum = mul_b_q[0] ? (prod_q + mul_a_q) : prod_q;

    always_comb begin
        state_d      = state_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        prod_d       = prod_q;
        cnt_d        = cnt_q;
        mul_tag_d    = mul_tag_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        cmp_flags_d  = cmp_flags_q;

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    if (in_op == OP_MUL) begin
                        mul_a_d   = in_a;
                        mul_b_d   = b_eff;
                        mul_tag_d = in_tag;
                        prod_d    = '0;
                        cnt_d     = '0;
                        state_d   = MUL;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_result_d = alu_result;
                        out_tag_d    = in_tag;
                    end
                    if (in_op == OP_CMP) begin
                        if (in_a == b_eff)     cmp_flags_d = 2'd1;
                        else if (in_a > b_eff) cmp_flags_d = 2'd2;
                        else                   cmp_flags_d = 2'd0;
                    end
                end
            end
            MUL: begin
                mul_a_d = mul_a_q << 1;
                mul_b_d = mul_b_q >> 1;
                prod_d  = prod_sum;
                cnt_d   = cnt_q + CNTW'(1);
                // The output register is guaranteed empty here: MUL was only accepted when it was free.
                if (cnt_q == CNT_LAST) begin
                    out_valid_d  = 1'b1;
                    out_result_d = prod_sum;
                    out_tag_d    = mul_tag_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            prod_q       <= '0;
            cnt_q        <= '0;
            mul_tag_q    <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            cmp_flags_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            prod_q       <= prod_d;
            cnt_q        <= cnt_d;
            mul_tag_q    <= mul_tag_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            cmp_flags_q  <= cmp_flags_d;
        end
    end

endmodule
